pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl
//  Purpose  : Pipeline hazard controller. Freezes stages on hazards and memory
//             waits, and issues flush/redirect pulses on requests or bus timeouts.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_ctrl #(
   parameter int unsigned TIMEOUT    = 16,
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_id,
   input  logic        stallreq_ex,
   input  logic        mem_req,
   input  logic        mem_ack,
   input  logic        flush_req,
   input  logic [31:0] flush_pc,
   output logic [5:0]  stall,
   output logic        flush,
   output logic [31:0] new_pc,
   output logic        bus_err
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_MEM_WAIT = 2'd1,
      S_FLUSH    = 2'd2
   } state_t;

   localparam logic [7:0] c_tmo_last  = 8'(TIMEOUT - 1);
   localparam logic [5:0] c_stall_mem = 6'b011111;
   localparam logic [5:0] c_stall_ex  = 6'b001111;
   localparam logic [5:0] c_stall_id  = 6'b000111;

   state_t      state_q;
   logic [7:0]  cnt_q;
   logic        pend_q;
   logic [31:0] pend_pc_q;
   logic [31:0] new_pc_q;

   logic        w_idle_wait;
   logic        w_timeout;

   assign w_idle_wait = (state_q == S_IDLE) && mem_req && !mem_ack;
   assign w_timeout   = (state_q == S_MEM_WAIT) && !mem_ack && (cnt_q == c_tmo_last);

   // bus_err must coincide with the last wait cycle, so it is decoded from state
   assign bus_err = w_timeout && !rst;
   assign flush   = (state_q == S_FLUSH);
   assign new_pc  = new_pc_q;

   always_comb begin
      stall = 6'b000000;
      if (rst || state_q == S_FLUSH) begin
         stall = 6'b000000;
      end else if (state_q == S_MEM_WAIT || w_idle_wait) begin
         stall = c_stall_mem;
      end else if (stallreq_ex) begin
         stall = c_stall_ex;
      end else if (stallreq_id) begin
         stall = c_stall_id;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= 8'd0;
         pend_q    <= 1'b0;
         pend_pc_q <= 32'h0;
         new_pc_q  <= 32'h0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (mem_req && !mem_ack) begin
                  // memory access wins; a simultaneous redirect waits behind it
                  state_q <= S_MEM_WAIT;
                  cnt_q   <= 8'd0;
                  pend_q  <= flush_req;
                  if (flush_req) begin
                     pend_pc_q <= flush_pc;
                  end
               end else if (flush_req) begin
                  state_q  <= S_FLUSH;
                  new_pc_q <= flush_pc;
               end
            end

            S_MEM_WAIT: begin
               if (mem_ack) begin
                  cnt_q  <= 8'd0;
                  pend_q <= 1'b0;
                  if (flush_req) begin
                     state_q  <= S_FLUSH;
                     new_pc_q <= flush_pc;
                  end else if (pend_q) begin
                     state_q  <= S_FLUSH;
                     new_pc_q <= pend_pc_q;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end else if (w_timeout) begin
                  // the exception vector supersedes any pending redirect
                  state_q  <= S_FLUSH;
                  new_pc_q <= EXC_VECTOR;
                  cnt_q    <= 8'd0;
                  pend_q   <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
                  if (flush_req) begin
                     pend_q    <= 1'b1;
                     pend_pc_q <= flush_pc;
                  end
               end
            end

            S_FLUSH: begin
               if (flush_req) begin
                  state_q  <= S_FLUSH;
                  new_pc_q <= flush_pc;
               end else begin
                  state_q <= S_IDLE;
               end
            end

            default: begin
               state_q <= S_IDLE;
               cnt_q   <= 8'd0;
               pend_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
